// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART register map, status layout, FSM states and baud divider
package uart_pkg;

    localparam logic [1:0] UART_RX_DATA = 2'd0;
    localparam logic [1:0] UART_RX_STAT = 2'd1;
    localparam logic [1:0] UART_RX_CTRL = 2'd2;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_FRAME_ERR = 2;
    localparam int STAT_OVERRUN   = 3;

    // Control writes clear a flag by writing 1 to the flag's own status bit position.
    localparam int CTRL_CLR_FRAME_ERR = STAT_FRAME_ERR;
    localparam int CTRL_CLR_OVERRUN   = STAT_OVERRUN;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    function automatic int uart_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - synchronous FIFO, power-of-two depth, extra pointer bit for full/empty
module rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp_q;
    logic [AW:0]      rp_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wp_q == rp_q);
    assign full     = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign pop_data = mem[rp_q[AW-1:0]];

    // A pop frees the slot in the same cycle, so a push into a full FIFO is accepted then.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + 1'b1;
            if (do_pop)  rp_q <= rp_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - bus-attached 8N1 UART receiver with receive FIFO and sticky error flags
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] addr,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rx
);

    localparam int DIV = uart_div(CLK_HZ, BAUD);
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    logic [1:0]    sync_q;
    logic          rxs;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          push;
    logic          frame_set;
    logic          overrun_set;
    logic          overrun_q;
    logic          frame_err_q;
    logic          pop_req;
    logic          clr_write;
    logic [7:0]    head;
    logic          full;
    logic          empty;
    logic [7:0]    status;
    logic [7:0]    rd_mux;
    logic [7:0]    rd_data_q;
    logic          rd_valid_q;
    logic          unused_wr_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], rx};
    end
    assign rxs = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    // Start bit is checked at half a bit, then every DIV cycles lands mid-bit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rxs) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!rxs) begin
                        state_d = RX_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    shreg_d = {rxs, shreg_q[7:1]};
                    cnt_d   = '0;
                    if (idx_q == 3'd7) state_d = RX_STOP;
                    else               idx_d   = idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rxs) push      = 1'b1;
                    else     frame_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign pop_req     = rd_en && (addr == UART_RX_DATA);
    assign overrun_set = push && full && !pop_req;
    assign clr_write   = wr_en && (addr == UART_RX_CTRL);

    rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (shreg_q),
        .pop       (pop_req),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    // A set in the same cycle as a clear leaves the flag raised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (overrun_set)
                overrun_q <= 1'b1;
            else if (clr_write && wr_data[CTRL_CLR_OVERRUN])
                overrun_q <= 1'b0;
            if (frame_set)
                frame_err_q <= 1'b1;
            else if (clr_write && wr_data[CTRL_CLR_FRAME_ERR])
                frame_err_q <= 1'b0;
        end
    end

    assign unused_wr_bits = ^{wr_data[7:4], wr_data[1:0]};

    always_comb begin
        status                 = '0;
        status[STAT_NOT_EMPTY] = !empty;
        status[STAT_FULL]      = full;
        status[STAT_FRAME_ERR] = frame_err_q;
        status[STAT_OVERRUN]   = overrun_q;
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            UART_RX_DATA: rd_mux = empty ? 8'h00 : head;
            UART_RX_STAT: rd_mux = status;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= rd_mux;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx at DIV=16
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [1:0] addr    = 2'd0;
    logic       rd_en   = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rx      = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    uart_rx #(
        .CLK_HZ     (1600000),
        .BAUD       (100000),
        .FIFO_DEPTH (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rx       (rx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    endtask

    // 16 clocks per bit; rx changes 1 ns after a rising edge.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(posedge clk); #1 rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (16) @(posedge clk); #1 rx = b[i];
        end
        repeat (16) @(posedge clk); #1 rx = stop;
        repeat (16) @(posedge clk); #1 rx = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d, output logic v);
        @(posedge clk); #1 addr = a; rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0; d = rd_data; v = rd_valid;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk); #1 addr = a; wr_data = d; wr_en = 1'b1;
        @(posedge clk); #1 wr_en = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        logic       v;
        bus_read(a, d, v);
        check(tag, d, exp);
    endtask

    initial begin
        logic [7:0] d;
        logic       v;
        logic [7:0] pat;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_rd_valid", {7'd0, rd_valid}, 8'h00);
        check("reset_rd_data", rd_data, 8'h00);
        read_check("reset_status", 2'd1, 8'h00);
        read_check("reset_data_empty", 2'd0, 8'h00);

        // 1: single frame
        send_frame(8'h55, 1'b1);
        read_check("t1_status", 2'd1, 8'h01);
        bus_read(2'd0, d, v);
        check("t1_data", d, 8'h55);
        check("t1_rd_valid", {7'd0, v}, 8'h01);
        @(posedge clk); #1;
        check("t1_valid_drop", {7'd0, rd_valid}, 8'h00);
        check("t1_data_hold", rd_data, 8'h55);
        read_check("t1_status_after", 2'd1, 8'h00);
        read_check("t1_addr3", 2'd3, 8'h00);

        // 2: short glitch on rx
        @(posedge clk); #1 rx = 1'b0;
        repeat (4) @(posedge clk); #1 rx = 1'b1;
        repeat (30) @(posedge clk);
        read_check("t2_glitch_status", 2'd1, 8'h00);
        send_frame(8'hA7, 1'b1);
        read_check("t2_data", 2'd0, 8'hA7);

        // 3: framing error
        send_frame(8'hA3, 1'b0);
        read_check("t3_status", 2'd1, 8'h04);
        read_check("t3_data_empty", 2'd0, 8'h00);
        bus_write(2'd0, 8'h04);
        read_check("t3_wr_addr0_ignored", 2'd1, 8'h04);
        bus_write(2'd2, 8'h04);
        read_check("t3_status_clr", 2'd1, 8'h00);

        // 4: overrun on the ninth frame
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
        read_check("t4_status", 2'd1, 8'h0B);
        for (int i = 1; i <= 8; i++) read_check("t4_data", 2'd0, 8'(i));
        read_check("t4_status_after", 2'd1, 8'h08);
        bus_write(2'd2, 8'h08);
        read_check("t4_status_clr", 2'd1, 8'h00);

        // 5: pop in the exact push cycle of a full FIFO
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1);
        read_check("t5_full_status", 2'd1, 8'h03);
        fork
            send_frame(8'h10, 1'b1);
            begin
                repeat (154) @(posedge clk);
                bus_read(2'd0, d, v);
            end
        join
        check("t5_same_cycle_pop", d, 8'h01);
        read_check("t5_status_no_overrun", 2'd1, 8'h03);
        for (int i = 2; i <= 8; i++) read_check("t5_old_data", 2'd0, 8'(i));
        read_check("t5_new_data", 2'd0, 8'h10);
        read_check("t5_status_end", 2'd1, 8'h00);

        // 6: reset pulse during data bit 4
        pat = 8'h5A;
        @(posedge clk); #1 rx = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (16) @(posedge clk); #1 rx = pat[i];
        end
        repeat (8) @(posedge clk); #1 rst_n = 1'b0;
        repeat (3) @(posedge clk); #1 rst_n = 1'b1; rx = 1'b1;
        check("t6_rd_valid", {7'd0, rd_valid}, 8'h00);
        repeat (40) @(posedge clk);
        read_check("t6_status", 2'd1, 8'h00);
        send_frame(8'h3C, 1'b1);
        read_check("t6_data", 2'd0, 8'h3C);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
